// File: rtl/apple1_term_writer.sv
// Writer side of the Apple-1 terminal character memory.
// Takes ASCII characters, turns them into 6-bit codes and drives the shift,
// data and recirculate controls of the SLOTS-slot recirculating shift
// register so that each character is stored in the slot under the cursor.
// An end of line (CR or column wrap) pulses line_done and then writes spaces
// into every slot during one full pass.
//
// Optional feature: define LOWERCASE_FOLD_EN to fold 0x60-0x7E to upper case.
// When it is not defined, those codes are consumed and dropped.
//
// Ports:
//   clock          system clock, all state changes on posedge
//   reset          synchronous active-high reset
//   slot_tick      one-cycle strobe per character time
//   char_in        7-bit ASCII character
//   char_valid     char_in is valid
//   char_ready     block can accept a character
//   sr_shift       shift enable to the memory, one cycle per slot
//   sr_in          6-bit code written when sr_recirculate is 0
//   sr_recirculate 1 keeps the stored slot, 0 replaces it with sr_in
//   cursor_col     current cursor column
//   line_done      one-cycle pulse at end of line
module apple1_term_writer #(
  parameter int unsigned SLOTS = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       slot_tick,
  input  logic [6:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       sr_shift,
  output logic [5:0] sr_in,
  output logic       sr_recirculate,
  output logic [5:0] cursor_col,
  output logic       line_done
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);
  localparam logic [CW-1:0] SPACE_CODE = 6'h20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DROP,
    EOL,
    CLEAR
  } state_t;

  state_t          state;
  logic [CW-1:0]   slot;
  logic [CW-1:0]   code;
  logic            clr_active;

  logic            is_print_c;
  logic            is_cr_c;
  logic [CW-1:0]   code_c;
  logic            xfer_c;
  logic            slot_match_c;

  // Classify the incoming character and form its 6-bit code.
  always_comb begin
    is_print_c = 1'b0;
    is_cr_c    = 1'b0;
    code_c     = char_in[5:0];
    if (char_in == 7'h0D) begin
      is_cr_c = 1'b1;
    end else if ((char_in >= 7'h20) && (char_in <= 7'h5F)) begin
      is_print_c = 1'b1;
`ifdef LOWERCASE_FOLD_EN
    end else if ((char_in >= 7'h60) && (char_in <= 7'h7E)) begin
      is_print_c = 1'b1;
      code_c     = CW'(char_in - 7'h20);
`endif
    end
  end

  assign xfer_c       = char_valid && char_ready;
  assign slot_match_c = slot_tick && (slot == cursor_col);

  // Slot counter, control FSM and registered memory controls.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      slot           <= '0;
      code           <= '0;
      clr_active     <= 1'b0;
      char_ready     <= 1'b0;
      sr_shift       <= 1'b0;
      sr_in          <= '0;
      sr_recirculate <= 1'b1;
      cursor_col     <= '0;
      line_done      <= 1'b0;
    end else begin
      // Every tick shifts one slot; non-target slots keep their contents.
      sr_shift       <= slot_tick;
      sr_recirculate <= 1'b1;
      sr_in          <= '0;
      line_done      <= 1'b0;

      if (slot_tick) begin
        slot <= (slot == LAST_SLOT) ? '0 : CW'(slot + 1'b1);
      end

      case (state)
        IDLE: begin
          char_ready <= 1'b1;
          if (xfer_c) begin
            char_ready <= 1'b0;
            if (is_cr_c) begin
              state <= EOL;
            end else if (is_print_c) begin
              code  <= code_c;
              state <= WAIT;
            end else begin
              state <= DROP;
            end
          end
        end

        // Ticks in the transfer cycle are seen in IDLE, so a same-cycle
        // match is naturally deferred to the next pass.
        WAIT: begin
          if (slot_match_c) begin
            sr_recirculate <= 1'b0;
            sr_in          <= code;
            if (cursor_col == LAST_SLOT) begin
              state <= EOL;
            end else begin
              cursor_col <= CW'(cursor_col + 1'b1);
              char_ready <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        DROP: begin
          char_ready <= 1'b1;
          state      <= IDLE;
        end

        EOL: begin
          line_done  <= 1'b1;
          cursor_col <= '0;
          clr_active <= 1'b0;
          state      <= CLEAR;
        end

        // The blanking pass starts at slot 0 and covers every slot once.
        CLEAR: begin
          if (slot_tick && (clr_active || (slot == '0))) begin
            sr_recirculate <= 1'b0;
            sr_in          <= SPACE_CODE;
            clr_active     <= 1'b1;
            if (slot == LAST_SLOT) begin
              clr_active <= 1'b0;
              char_ready <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apple1_term_writer.sv
// Scoreboard bench for apple1_term_writer: expected slot writes are queued
// when characters are sent and matched against observed memory writes.
module tb_apple1_term_writer;

  localparam int SLOTS = 40;

  typedef struct packed {
    logic [5:0] slot;
    logic [5:0] data;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       slot_tick = 1'b0;
  logic [6:0] char_in = 7'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       sr_shift;
  logic [5:0] sr_in;
  logic       sr_recirculate;
  logic [5:0] cursor_col;
  logic       line_done;

  apple1_term_writer #(.SLOTS(SLOTS)) dut (
    .clock          (clock),
    .reset          (reset),
    .slot_tick      (slot_tick),
    .char_in        (char_in),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .sr_shift       (sr_shift),
    .sr_in          (sr_in),
    .sr_recirculate (sr_recirculate),
    .cursor_col     (cursor_col),
    .line_done      (line_done)
  );

  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  sb_q[$];
  int   mon_slot = 0;
  int   ld_count = 0;
  int   exp_ld = 0;
  int   cur = 0;
  logic prev_ld = 1'b0;
  logic tick_seen = 1'b0;
  logic tick_en = 1'b0;
  int   gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic nwait();
    @(negedge clock);
    #1;
  endtask

  // Slot ticks with random spacing (every 1 to 4 cycles).
  always @(negedge clock) begin
    if (tick_en && gap == 0) begin
      slot_tick = 1'b1;
      gap = $urandom_range(3, 0);
    end else begin
      slot_tick = 1'b0;
      if (gap > 0) gap = gap - 1;
    end
  end

  always @(posedge clock) tick_seen <= slot_tick && !reset;

  // Monitor: shift timing, idle recirculate, write scoreboard, line_done pulses.
  always @(negedge clock) begin
    if (reset) begin
      mon_slot = 0;
      prev_ld  = 1'b0;
    end else begin
      check("shift_timing", sr_shift, tick_seen);
      if (sr_shift) begin
        if (!sr_recirculate) begin
          check("write_pending", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            wr_t e;
            e = sb_q.pop_front();
            check("wr_slot", mon_slot, e.slot);
            check("wr_data", sr_in, e.data);
          end
        end
        mon_slot = (mon_slot == SLOTS - 1) ? 0 : mon_slot + 1;
      end else begin
        check("recirc_idle", sr_recirculate, 1);
      end
      if (line_done) begin
        ld_count++;
        check("ld_width", prev_ld, 0);
      end
      prev_ld = line_done;
    end
  end

  task automatic push_clear();
    for (int i = 0; i < SLOTS; i++) sb_q.push_back({6'(i), 6'h20});
    exp_ld++;
    cur = 0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!char_ready && n < 1000) begin
      nwait();
      n++;
    end
    check("ready_wait", char_ready, 1);
  endtask

  task automatic send_char(input logic [6:0] c);
    int         kind;
    logic [5:0] code;
    kind = 0;
    code = c[5:0];
    if (c == 7'h0D) kind = 2;
    else if (c >= 7'h20 && c <= 7'h5F) kind = 1;
`ifdef LOWERCASE_FOLD_EN
    else if (c >= 7'h60 && c <= 7'h7E) begin
      kind = 1;
      code = 6'(c - 7'h20);
    end
`endif
    wait_ready();
    char_in    = c;
    char_valid = 1'b1;
    nwait();
    char_valid = 1'b0;
    check("ready_low_after_xfer", char_ready, 0);
    if (kind == 1) begin
      sb_q.push_back({6'(cur), code});
      if (cur == SLOTS - 1) push_clear();
      else cur++;
    end else if (kind == 2) begin
      push_clear();
    end
    if (kind == 0) begin
      nwait();
      check("drop_ready_2cyc", char_ready, 1);
    end else begin
      wait_ready();
    end
    nwait();
    check("cursor_col", cursor_col, cur);
    check("line_done_cnt", ld_count, exp_ld);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) nwait();
    reset = 1'b0;
    #1;
    check("rst_ready", char_ready, 0);
    check("rst_recirc", sr_recirculate, 1);
    check("rst_shift", sr_shift, 0);
    check("rst_cursor", cursor_col, 0);
    check("rst_line_done", line_done, 0);
    nwait();
    check("ready_after_rst", char_ready, 1);
    tick_en = 1'b1;

    send_char(7'h41);
    send_char(7'h61);
    send_char(7'h07);
    send_char(7'h7F);
    send_char(7'h60);
    send_char(7'h7E);
    send_char(7'h5F);
    send_char(7'h20);
    send_char(7'h1F);

    // Fill to the end of the line so the column wraps.
    begin
      int k;
      k = SLOTS - cur;
      repeat (k) send_char(7'h42);
    end

    // CR at column 5.
    repeat (5) send_char(7'h43);
    check("cursor_before_cr", cursor_col, 5);
    send_char(7'h0D);

    // Reset in the middle of the blanking pass, right after slot 12.
    repeat (3) send_char(7'h44);
    wait_ready();
    char_in    = 7'h0D;
    char_valid = 1'b1;
    nwait();
    char_valid = 1'b0;
    push_clear();
    begin
      int n;
      n = 0;
      while (!(sb_q.size() > 0 && sb_q[0].slot == 6'd13) && n < 1000) begin
        nwait();
        n++;
      end
      check("clear_reached_slot12", sb_q.size() > 0 && sb_q[0].slot == 6'd13, 1);
    end
    reset = 1'b1;
    nwait();
    check("midclr_recirc", sr_recirculate, 1);
    check("midclr_shift", sr_shift, 0);
    check("midclr_ready", char_ready, 0);
    check("midclr_cursor", cursor_col, 0);
    reset = 1'b0;
    sb_q.delete();
    cur = 0;
    // A write at slot 0 shows the slot counter restarted.
    send_char(7'h41);

    repeat (300) nwait();
    check("final_sb_empty", sb_q.size(), 0);
    check("final_cursor", cursor_col, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
